fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 129 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Four-requester round-robin burst arbiter feeding one shared sync FIFO write port.
// Optional owner-stall statistics counter enabled by defining FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter int DW       = 16,
  parameter int MAXBURST = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic [3:0]      req,
  input  logic [3:0]      last,
  input  logic [4*DW-1:0] req_data,
  input  logic            fifo_full,
  output logic [3:0]      gnt,
  output logic [3:0]      ack,
  output logic            fifo_wr,
  output logic [DW-1:0]   fifo_wdata,
  output logic [15:0]     stall_cnt
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t      r_state;
  logic [3:0]  r_gnt;
  logic [1:0]  r_owner;
  logic [1:0]  r_rr_ptr;
  logic [7:0]  r_beat_cnt;

  logic        w_in_burst;
  logic        w_owner_req;
  logic        w_accept;
  logic        w_found;
  logic [1:0]  w_win;
  logic [1:0]  w_idx;
  logic [7:0]  w_beat_next;
  logic [DW-1:0] w_owner_data;

  assign w_in_burst  = (r_state == BURST);
  assign w_owner_req = req[r_owner];
  assign w_accept    = w_in_burst && w_owner_req && !fifo_full && !flush;
  assign w_beat_next = r_beat_cnt + 8'd1;

  // First set request at or above rr_ptr, wrapping 3->0.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      w_idx = r_rr_ptr + 2'(k);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_owner_data = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (r_owner == 2'(k)) w_owner_data = req_data[k*DW +: DW];
    end
  end

  assign gnt        = r_gnt;
  assign fifo_wr    = w_accept;
  assign ack        = w_accept ? r_gnt : '0;
  assign fifo_wdata = w_in_burst ? w_owner_data : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else if (flush) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state    <= BURST;
            r_gnt      <= 4'b0001 << w_win;
            r_owner    <= w_win;
            r_beat_cnt <= '0;
          end
        end
        BURST: begin
          if (!w_owner_req) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_rr_ptr <= r_owner + 2'd1;
          end else if (!fifo_full) begin
            r_beat_cnt <= w_beat_next;
            if (last[r_owner] || (w_beat_next == 8'(MAXBURST))) begin
              r_state  <= IDLE;
              r_gnt    <= '0;
              r_rr_ptr <= r_owner + 2'd1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] r_stall_cnt;

  // Stalls are counted even on a flush cycle; only reset clears the counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_stall_cnt <= '0;
    else if (w_in_burst && w_owner_req && fifo_full && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized + directed bench for fifo_wr_arbiter against a transaction-level owner/beat model.
module tb_fifo_wr_arbiter;

  localparam int DW = 16;
  localparam int MB = 8;
`ifdef FIFO_WR_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset_n;
  logic            flush;
  logic [3:0]      req;
  logic [3:0]      last;
  logic [4*DW-1:0] req_data;
  logic            fifo_full;
  logic [3:0]      gnt;
  logic [3:0]      ack;
  logic            fifo_wr;
  logic [DW-1:0]   fifo_wdata;
  logic [15:0]     stall_cnt;

  fifo_wr_arbiter #(.DW(DW), .MAXBURST(MB)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .req(req), .last(last),
    .req_data(req_data), .fifo_full(fifo_full), .gnt(gnt), .ack(ack),
    .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_seen = 0;
  int grants[$];
  logic [3:0] prev_gnt;

  // Model: who owns the port, how many beats it has moved, round-robin start, stall total.
  int m_owner, m_beats, m_rr, m_stall;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_beats = 0; m_rr = 0; m_stall = 0;
  endtask

  task automatic compare_all();
    logic [3:0] eg, ea;
    logic ew;
    logic [DW-1:0] ed;
    eg = '0; ea = '0; ew = 1'b0; ed = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      ew = req[m_owner] && !fifo_full && !flush;
      ed = req_data[m_owner*DW +: DW];
      if (ew) ea[m_owner] = 1'b1;
    end
    chk("gnt", 32'(gnt), 32'(eg));
    chk("ack", 32'(ack), 32'(ea));
    chk("fifo_wr", 32'(fifo_wr), 32'(ew));
    chk("fifo_wdata", 32'(fifo_wdata), 32'(ed));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    if (fifo_wr === 1'b1) wr_seen++;
    if (prev_gnt == 4'd0 && gnt != 4'd0) grants.push_back(int'(gnt));
    prev_gnt = gnt;
  endtask

  task automatic model_update();
    int o;
    if (STATS && m_owner >= 0 && req[m_owner] && fifo_full && m_stall < 65535) m_stall++;
    if (flush) begin
      m_owner = -1; m_beats = 0; m_rr = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        o = (m_rr + k) % 4;
        if (m_owner < 0 && req[o]) begin m_owner = o; m_beats = 0; end
      end
    end else if (!req[m_owner]) begin
      m_rr = (m_owner + 1) % 4; m_owner = -1;
    end else if (!fifo_full) begin
      m_beats++;
      if (last[m_owner] || m_beats == MB) begin
        m_rr = (m_owner + 1) % 4; m_owner = -1;
      end
    end
  endtask

  // Inputs are set just after an edge; outputs are checked mid-cycle, then the model advances on the edge.
  task automatic step();
    #2;
    compare_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; flush = 1'b0; req = '0; last = '0; fifo_full = 1'b0;
    req_data = {$urandom, $urandom};
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    prev_gnt = '0;
    grants.delete();
    wr_seen = 0;
  endtask

  int w0;

  initial begin
    do_reset();
    #2;
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_stall", 32'(stall_cnt), 32'h0);

    // Single requester, last on the third beat.
    req = 4'b0001;
    step();
    chk("first_grant", 32'(gnt), 32'h1);
    for (int j = 0; j < 3; j++) begin
      last = (j == 2) ? 4'b0001 : 4'b0000;
      req_data = {$urandom, $urandom};
      step();
    end
    last = '0;
    chk("three_beats", 32'(wr_seen), 32'd3);
    req = 4'b1111;
    step();
    chk("rr_after_req0", 32'(gnt), 32'h2);

    // All requesting continuously: 0,1,2,3,0, eight beats each.
    do_reset();
    req = 4'b1111;
    for (int j = 0; j < 45; j++) begin
      req_data = {$urandom, $urandom};
      step();
    end
    chk("grant_count", 32'(grants.size()), 32'd5);
    if (grants.size() == 5) begin
      chk("grant_order", {grants[0][3:0], grants[1][3:0], grants[2][3:0], grants[3][3:0], grants[4][3:0], 12'h0},
          32'h1248_1000);
    end
    chk("beats_total", 32'(wr_seen), 32'd40);

    // Owner 2 stalled by a full FIFO for five cycles.
    do_reset();
    req = 4'b0100;
    repeat (3) step();
    w0 = wr_seen;
    fifo_full = 1'b1;
    repeat (5) step();
    chk("no_wr_while_full", 32'(wr_seen - w0), 32'd0);
    fifo_full = 1'b0;
    #2;
    chk("stall_total", 32'(stall_cnt), STATS ? 32'd5 : 32'd0);
    step();
    chk("resume_wr", 32'(wr_seen - w0), 32'd1);

    // Owner 1 drops its request with requester 3 waiting.
    do_reset();
    req = 4'b1010;
    repeat (3) step();
    req = 4'b1000;
    step();
    chk("drop_idle", 32'(gnt), 32'h0);
    step();
    chk("drop_next_owner", 32'(gnt), 32'h8);

    // Flush during the fourth beat of owner 3.
    do_reset();
    req = 4'b1000;
    repeat (4) step();
    req = 4'b1001;
    flush = 1'b1;
    #1;
    chk("flush_wr", 32'(fifo_wr), 32'h0);
    step();
    flush = 1'b0;
    chk("flush_gnt", 32'(gnt), 32'h0);
    step();
    chk("flush_rr0", 32'(gnt), 32'h1);

    // Asynchronous reset mid-burst.
    do_reset();
    req = 4'b0001;
    fifo_full = 1'b1;
    repeat (3) step();
    fifo_full = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("areset_gnt", 32'(gnt), 32'h0);
    chk("areset_wr", 32'(fifo_wr), 32'h0);
    chk("areset_ack", 32'(ack), 32'h0);
    chk("areset_stall", 32'(stall_cnt), 32'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    prev_gnt = '0;

    // Random traffic against the model.
    for (int j = 0; j < 3000; j++) begin
      req       = 4'($urandom_range(0, 15)) | ((j % 97 < 40) ? 4'b1111 : 4'b0000);
      last      = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      fifo_full = ($urandom_range(0, 4) == 0);
      flush     = ($urandom_range(0, 39) == 0);
      req_data  = {$urandom, $urandom};
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
